// File: rtl/instr_fetch.sv
// ----------------------------------------------------------------------------
// instr_fetch : single-issue instruction fetch stage.
//
// Issues word-aligned requests to instruction memory and registers the
// returned word together with its address + 4.
//
// Redirect handling:
// - A taken branch flushes the registered instruction.
// - If the branch arrives while a request is outstanding (requested but not
//   acknowledged), that request is held stable in DRAIN until its ack
//   arrives. The returned data is dropped, and fetch then resumes at the
//   redirect pc.
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   imem_req/addr    memory request, held stable until imem_ack
//   imem_ack/rdata   memory completion and data
//   stall            downstream cannot take a new instruction
//   branch_taken/    redirect request and target (target bits [1:0]
//   branch_target    are ignored)
//   if_valid/instr/  registered instruction, its address + 4
//   if_pc4
//   opcode           if_instr[31:26]
//
// Optional build macro FETCH_PERF_EN adds two counters:
//   fetch_cnt   counts accepted fetches whose data is kept.
//   bubble_cnt  counts non-reset cycles with if_valid low.
// ----------------------------------------------------------------------------
module instr_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic        if_valid,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc4,
   output logic [5:0]  opcode
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0] fetch_cnt,
   output logic [31:0] bubble_cnt
`endif
);

   typedef enum logic {FETCH, DRAIN} fetchState_t;

   fetchState_t state;
   logic [31:0] pc;          // always word aligned
   logic [31:0] drainAddr;   // address of the request abandoned by a redirect
   logic [31:0] pcNext;
   logic [31:0] redirectPc;
   logic        adv;
   logic        fetchDone;
   logic [1:0]  unusedTgtBits;

   assign unusedTgtBits = branch_target[1:0];
   assign redirectPc    = {branch_target[31:2], 2'b00};
   assign pcNext        = pc + 32'd4;   // wraps 32'hFFFF_FFFC -> 0
   assign adv           = !stall || !if_valid;

   // In FETCH, a request can only drop while it is unacked if stall rises
   // with if_valid high. if_valid can only be high on an unacked request when
   // stall was low, and the next edge then clears if_valid. That keeps adv
   // high, so an outstanding request stays up until acked.
   assign imem_req  = !rst && ((state == DRAIN) || adv);
   assign imem_addr = (state == DRAIN) ? drainAddr : pc;
   assign opcode    = if_instr[31:26];

   assign fetchDone = (state == FETCH) && imem_req && imem_ack && !branch_taken;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= FETCH;
         pc        <= {RESET_PC[31:2], 2'b00};
         drainAddr <= 32'd0;
         if_valid  <= 1'b0;
         if_instr  <= 32'd0;
         if_pc4    <= 32'd0;
      end else begin
         case (state)
            FETCH: begin
               if (branch_taken) begin
                  // Flush has priority over stall and over any data this cycle.
                  if_valid <= 1'b0;
                  pc       <= redirectPc;
                  if (imem_req && !imem_ack) begin
                     drainAddr <= pc;
                     state     <= DRAIN;
                  end
               end else if (imem_req && imem_ack) begin
                  if_instr <= imem_rdata;
                  if_pc4   <= pcNext;
                  if_valid <= 1'b1;
                  pc       <= pcNext;
               end else if (!stall) begin
                  if_valid <= 1'b0;
               end
            end
            DRAIN: begin
               // The stale data is dropped. A later redirect only moves the
               // resume point.
               if (branch_taken) pc <= redirectPc;
               if (imem_ack) state <= FETCH;
            end
            default: state <= FETCH;
         endcase
      end
   end

`ifdef FETCH_PERF_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_cnt  <= 32'd0;
         bubble_cnt <= 32'd0;
      end else begin
         if (fetchDone) fetch_cnt  <= fetch_cnt + 32'd1;
         if (!if_valid) bubble_cnt <= bubble_cnt + 32'd1;
      end
   end
`else
   logic unusedFetchDone;
   assign unusedFetchDone = fetchDone;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch.
// Inputs are driven 1 time unit after the rising edge.
// Outputs are sampled on the falling edge.
// A second instance with RESET_PC = 32'hFFFF_FFFC shares all inputs, but its
// outputs are only checked in the first fetch.
module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_target;

   logic        imem_req,  wReq;
   logic [31:0] imem_addr, wAddr;
   logic        if_valid,  wValid;
   logic [31:0] if_instr,  wInstr;
   logic [31:0] if_pc4,    wPc4;
   logic [5:0]  opcode,    wOpcode;
`ifdef FETCH_PERF_EN
   logic [31:0] fetch_cnt, bubble_cnt, wFetchCnt, wBubbleCnt;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
      .if_valid(if_valid), .if_instr(if_instr), .if_pc4(if_pc4), .opcode(opcode)
`ifdef FETCH_PERF_EN
      , .fetch_cnt(fetch_cnt), .bubble_cnt(bubble_cnt)
`endif
   );

   instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dutW (
      .clk(clk), .rst(rst),
      .imem_req(wReq), .imem_addr(wAddr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
      .if_valid(wValid), .if_instr(wInstr), .if_pc4(wPc4), .opcode(wOpcode)
`ifdef FETCH_PERF_EN
      , .fetch_cnt(wFetchCnt), .bubble_cnt(wBubbleCnt)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic edgeIn();   // advance past the next rising edge
      @(posedge clk); #1;
   endtask

   task automatic smp();      // settle to the sampling point
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'd0; stall = 1'b0;
      branch_taken = 1'b0; branch_target = 32'd0;

      // Reset state
      edgeIn(); edgeIn(); smp();
      chk("rst_req",   {31'd0, imem_req}, 32'd0);
      chk("rst_valid", {31'd0, if_valid}, 32'd0);
      chk("rst_instr", if_instr, 32'd0);
      chk("rst_pc4",   if_pc4,   32'd0);

      // First fetch: ack every cycle
      edgeIn(); rst = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h8C01_0004; smp();
      chk("f0_req",  {31'd0, imem_req}, 32'd1);
      chk("f0_addr", imem_addr, 32'h0000_0000);
      chk("w0_addr", wAddr,     32'hFFFF_FFFC);

      edgeIn(); imem_rdata = 32'h2002_0008; smp();
      chk("f0_valid",  {31'd0, if_valid}, 32'd1);
      chk("f0_instr",  if_instr, 32'h8C01_0004);
      chk("f0_opcode", {26'd0, opcode}, 32'b100011);
      chk("f0_pc4",    if_pc4,   32'd4);
      chk("f1_addr",   imem_addr, 32'd4);
      chk("w0_pc4",    wPc4,  32'd0);
      chk("w1_addr",   wAddr, 32'd0);

      // Stall for 3 cycles while valid: no request, outputs held
      edgeIn(); stall = 1'b1; smp();
      chk("f1_instr", if_instr, 32'h2002_0008);
      chk("f1_pc4",   if_pc4,   32'd8);
      for (int i = 0; i < 3; i++) begin
         chk("stl_req", {31'd0, imem_req}, 32'd0);
         edgeIn(); smp();
         chk("stl_instr", if_instr, 32'h2002_0008);
         chk("stl_pc4",   if_pc4,   32'd8);
      end
      chk("stl_req_end", {31'd0, imem_req}, 32'd0);

      // Release stall and branch to 0x103 with ack in the same cycle
      @(posedge clk); #1;
      stall = 1'b0; branch_taken = 1'b1; branch_target = 32'h0000_0103;
      imem_rdata = 32'hDEAD_BEEF; smp();
      chk("stl_addr", imem_addr, 32'd8);

      // Redirect to 0x20; the data acked at 0x100 is discarded
      edgeIn(); branch_target = 32'h0000_0020; imem_rdata = 32'h1111_1111; smp();
      chk("br0_valid", {31'd0, if_valid}, 32'd0);
      chk("br0_addr",  imem_addr, 32'h0000_0100);

      // Request at 0x20 goes unacked
      edgeIn(); branch_taken = 1'b0; imem_ack = 1'b0; smp();
      chk("br1_valid", {31'd0, if_valid}, 32'd0);
      chk("br1_addr",  imem_addr, 32'h0000_0020);
      edgeIn(); branch_taken = 1'b1; branch_target = 32'h0000_0100; smp();
      chk("pend_req",  {31'd0, imem_req}, 32'd1);
      chk("pend_addr", imem_addr, 32'h0000_0020);
      edgeIn(); branch_taken = 1'b0; smp();
      chk("drn_req",  {31'd0, imem_req}, 32'd1);
      chk("drn_addr", imem_addr, 32'h0000_0020);
      edgeIn(); imem_ack = 1'b1; imem_rdata = 32'hBADB_AD00; smp();
      chk("drn_addr2", imem_addr, 32'h0000_0020);
      edgeIn(); imem_rdata = 32'h0C00_0010; smp();
      chk("drn_drop",  {31'd0, if_valid}, 32'd0);
      chk("res_addr",  imem_addr, 32'h0000_0100);
      edgeIn(); smp();
      chk("res_valid",  {31'd0, if_valid}, 32'd1);
      chk("res_instr",  if_instr, 32'h0C00_0010);
      chk("res_opcode", {26'd0, opcode}, 32'b000011);
      chk("res_pc4",    if_pc4,   32'h0000_0104);

      // Branch and stall together: flush wins
      edgeIn(); stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h0000_0200; smp();
      chk("bs_req", {31'd0, imem_req}, 32'd0);
      edgeIn(); branch_taken = 1'b0; imem_ack = 1'b0; smp();
      chk("bs_valid", {31'd0, if_valid}, 32'd0);
      chk("bs_req2",  {31'd0, imem_req}, 32'd1);
      chk("bs_addr",  imem_addr, 32'h0000_0200);

      // Reset during an outstanding request
      edgeIn(); rst = 1'b1; smp();
      chk("rr_req", {31'd0, imem_req}, 32'd0);
      edgeIn(); rst = 1'b0; stall = 1'b0; smp();
      chk("rr_req2",  {31'd0, imem_req}, 32'd1);
      chk("rr_addr",  imem_addr, 32'h0000_0000);
      chk("rr_instr", if_instr, 32'd0);

`ifdef FETCH_PERF_EN
      // Performance counters: 5 accepted fetches, 2 bubbles
      edgeIn(); rst = 1'b1; smp();
      edgeIn(); rst = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h0000_0001; smp();
      chk("pc_rst_f", fetch_cnt,  32'd0);
      chk("pc_rst_b", bubble_cnt, 32'd0);
      for (int i = 0; i < 4; i++) begin
         edgeIn(); smp();
      end
      edgeIn(); imem_ack = 1'b0; smp();
      edgeIn(); smp();
      edgeIn(); rst = 1'b1; smp();
      chk("pc_fetch",  fetch_cnt,  32'd5);
      chk("pc_bubble", bubble_cnt, 32'd2);
      edgeIn(); rst = 1'b0; smp();
      chk("pc_clr_f", fetch_cnt,  32'd0);
      chk("pc_clr_b", bubble_cnt, 32'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
